// File: rtl/ula_pkg.sv
// ula_pkg: shared FSM encodings and opcode constants for the ULA add/sub path
package ula_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/FullAdder1Bit.sv
// FullAdder1Bit: single-bit full adder
module FullAdder1Bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial add/sub, LSB first, one full adder reused across WIDTH clocks
module serial_alu_sequencer
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);
    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh, b_sh, nxt;
    logic [CW-1:0]    cnt;
    logic             carry, s, co, accept;
    FullAdder1Bit u_fa (.A(a_sh[0]), .B(b_sh[0]), .Cin(carry), .S(s), .Cout(co));
    assign busy   = state == RUN;
    assign done   = state == DONE;
    assign accept = start && state != RUN;
    assign nxt    = {s, result[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= op_sub == OP_ADD ? b : ~b;
            carry <= op_sub == OP_SUB;
            cnt   <= '0;
            state <= RUN;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            result <= nxt;
            carry  <= co;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                overflow <= carry ^ co;
                cout     <= co;
                zero     <= nxt == '0;
                state    <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer: scoreboard bench with directed and random add/sub operations
module tb_serial_alu_sequencer;
    localparam int W = 8;
    typedef struct {
        logic [W-1:0] r;
        logic         c, v, z;
        int           t;
    } exp_t;

    logic         clk = 0, rst_n = 0, start = 0, op_sub = 0;
    logic [W-1:0] a = 0, b = 0, result;
    logic         busy, done, cout, overflow, zero;
    int           checks = 0, failures = 0, cyc = 0, done_cnt = 0;
    exp_t         q[$];

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
        exp_t e;
        int   sx, sy, sres, ures;
        sx   = int'($signed(x));
        sy   = int'($signed(y));
        sres = op ? sx - sy : sx + sy;
        ures = op ? int'(x) - int'(y) : int'(x) + int'(y);
        e.r  = W'(ures);
        e.c  = op ? (x >= y) : (ures >= (1 << W));
        e.v  = sres > (1 << (W - 1)) - 1 || sres < -(1 << (W - 1));
        e.z  = e.r == 0;
        e.t  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: done high with no pending op, result=%0h (cycle %0d)", result, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("cout", 32'(cout), 32'(e.c));
                chk("overflow", 32'(overflow), 32'(e.v));
                chk("zero", 32'(zero), 32'(e.z));
                chk("latency", 32'(cyc - e.t), 32'(W));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic op, input bit push);
        exp_t e;
        wait_idle();
        start = 1; a = x; b = y; op_sub = op;
        @(posedge clk);
        #1;
        if (push) begin
            e   = model(x, y, op);
            e.t = cyc;
            q.push_back(e);
        end
        start = 0;
        a = $urandom; b = $urandom; op_sub = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] tx[6] = '{8'h35, 8'hFF, 8'h7F, 8'h80, 8'h10, 8'h20};
        logic [W-1:0] ty[6] = '{8'h4A, 8'h01, 8'h01, 8'h01, 8'h20, 8'h20};
        logic         to[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int           d0;
        exp_t         e;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_cout", 32'(cout), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_zero", 32'(zero), 1);
        rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            issue(tx[i], ty[i], to[i], 1);
            drain();
        end

        d0 = done_cnt;
        issue(8'h11, 8'h22, 1'b0, 1);
        repeat (3) @(negedge clk);
        start = 1; a = 8'hAA; b = 8'h55; op_sub = 1;
        @(negedge clk);
        start = 0;
        drain();
        repeat (12) @(negedge clk);
        chk("ignore_single_done", 32'(done_cnt - d0), 1);

        wait_idle();
        start = 1; a = 8'h12; b = 8'h34; op_sub = 0;
        @(posedge clk);
        #1;
        e = model(8'h12, 8'h34, 0); e.t = cyc; q.push_back(e);
        a = 8'h90; b = 8'h10; op_sub = 1;
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            while (!done && n < 30) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_done_seen", 32'(done), 1);
            @(posedge clk);
            #1;
            e = model(a, b, op_sub); e.t = cyc; q.push_back(e);
            a = 8'hC3; b = 8'h3C; op_sub = 0;
        end
        start = 0;
        drain();

        issue(8'h55, 8'h66, 1'b0, 0);
        chk("run_busy", 32'(busy), 1);
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        rst_n = 0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_zero", 32'(zero), 1);
        @(negedge clk);
        rst_n = 1;
        repeat (15) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        issue(8'h0F, 8'hF1, 1'b0, 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
